// File: rtl/definitions_pkg.sv
// Shared image-pipeline definitions: frame geometry, pixel/window types and
// the 3x3 kernel index order used by the window generator and later stages.
package definitions_pkg;

  localparam int IMAGE_WIDTH  = 512;
  localparam int IMAGE_HEIGHT = 512;
  localparam int PIXEL_WIDTH  = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // Element k occupies bits [PIXEL_WIDTH*k +: PIXEL_WIDTH] when flattened.
  typedef pixel_t [8:0] pixel_window_t;

  // Row-major kernel order: T/M/B = rows r-2/r-1/r, L/C/R = cols c-2/c-1/c.
  typedef enum logic [3:0] {
    K_TL = 4'd0, K_TC = 4'd1, K_TR = 4'd2,
    K_ML = 4'd3, K_MC = 4'd4, K_MR = 4'd5,
    K_BL = 4'd6, K_BC = 4'd7, K_BR = 4'd8
  } kernel_idx_e;

endpackage

// File: rtl/window_line_ram.sv
// One image row of pixel storage: asynchronous read, synchronous write, no reset.
module window_line_ram #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-order pixel stream to 3x3 sliding windows (valid region only), with a
// single registered output stage and ready/valid flow control on both sides.
module window_gen_3x3 #(
  parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT,
  parameter int PIXEL_WIDTH  = definitions_pkg::PIXEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9*PIXEL_WIDTH-1:0] out_window,
  output logic                     out_last
);

  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             accept, qual, col_wrap, row_wrap;
  logic [PIXEL_WIDTH-1:0] lb_r1_rd, lb_r2_rd;

  // Column shift registers; index 0 is column c-2, index 2 is column c.
  logic [2:0][PIXEL_WIDTH-1:0] top_q, mid_q, bot_q;
  logic [8:0][PIXEL_WIDTH-1:0] win;
  logic                        out_valid_q, out_last_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign row_wrap = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign qual     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Row r-1 buffer shifts its old entry down into the row r-2 buffer.
  window_line_ram #(
    .DEPTH (IMAGE_WIDTH),
    .WIDTH (PIXEL_WIDTH),
    .ADDR_W(COL_W)
  ) u_lb_r1 (
    .clk  (clk),
    .we   (accept),
    .addr (col_q),
    .wdata(in_pixel),
    .rdata(lb_r1_rd)
  );

  window_line_ram #(
    .DEPTH (IMAGE_WIDTH),
    .WIDTH (PIXEL_WIDTH),
    .ADDR_W(COL_W)
  ) u_lb_r2 (
    .clk  (clk),
    .we   (accept),
    .addr (col_q),
    .wdata(lb_r1_rd),
    .rdata(lb_r2_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_wrap ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Shift registers only move on accept, so a stalled window is held for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept) begin
      top_q <= {lb_r2_rd, top_q[2], top_q[1]};
      mid_q <= {lb_r1_rd, mid_q[2], mid_q[1]};
      bot_q <= {in_pixel, bot_q[2], bot_q[1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (qual) begin
      out_valid_q <= 1'b1;
      out_last_q  <= row_wrap && col_wrap;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  always_comb begin
    win = '0;
    win[definitions_pkg::K_TL] = top_q[0];
    win[definitions_pkg::K_TC] = top_q[1];
    win[definitions_pkg::K_TR] = top_q[2];
    win[definitions_pkg::K_ML] = mid_q[0];
    win[definitions_pkg::K_MC] = mid_q[1];
    win[definitions_pkg::K_MR] = mid_q[2];
    win[definitions_pkg::K_BL] = bot_q[0];
    win[definitions_pkg::K_BC] = bot_q[1];
    win[definitions_pkg::K_BR] = bot_q[2];
  end

  assign out_window = win;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image: scoreboard fed from an image model,
// expected-window table, stall, back-to-back, mid-frame reset and random gaps.
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int WW = 9 * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
  logic          out_last;

  always #5 clk = ~clk;

  window_gen_3x3 #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window),
    .out_last  (out_last)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
  } exp_t;

  typedef struct {
    int            cap_idx;
    logic [WW-1:0] win;
    logic          last;
  } vec_t;

  exp_t sb_q[$];
  exp_t cap_q[$];
  vec_t tbl[5];

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] img [H][W];
  int  mr, mc, acc_cnt, first_valid_acc;
  bit  prev_stall;
  logic [WW-1:0] prev_win;
  logic prev_last;
  int  ready_mode;

  task automatic chk(input bit ok, input string name, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] w9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    logic [WW-1:0] w;
    w = '0;
    w[0*PW +: PW] = PW'(p0); w[1*PW +: PW] = PW'(p1); w[2*PW +: PW] = PW'(p2);
    w[3*PW +: PW] = PW'(p3); w[4*PW +: PW] = PW'(p4); w[5*PW +: PW] = PW'(p5);
    w[6*PW +: PW] = PW'(p6); w[7*PW +: PW] = PW'(p7); w[8*PW +: PW] = PW'(p8);
    return w;
  endfunction

  function automatic logic [WW-1:0] model_window(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[PW*k +: PW] = img[r-2+k/3][c-2+k%3];
    return w;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; acc_cnt = 0; first_valid_acc = -1;
    prev_stall = 0;
    sb_q.delete();
  endtask

  // Monitor / scoreboard: samples at negedge, ahead of the edge that commits.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk(in_ready === (!out_valid || out_ready), "in_ready_rule", WW'(in_ready),
            WW'(!out_valid || out_ready));
        if (prev_stall) begin
          chk(out_valid === 1'b1, "hold_valid", WW'(out_valid), WW'(1));
          chk(out_window === prev_win, "hold_window", out_window, prev_win);
          chk(out_last === prev_last, "hold_last", WW'(out_last), WW'(prev_last));
        end
        if (out_valid) begin
          if (first_valid_acc < 0) first_valid_acc = acc_cnt;
          if (sb_q.size() == 0) begin
            chk(1'b0, "spurious_valid", out_window, '0);
          end else if (out_ready) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(out_window === e.win, "window", out_window, e.win);
            chk(out_last === e.last, "last", WW'(out_last), WW'(e.last));
            cap_q.push_back('{out_window, out_last});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_win   = out_window;
        prev_last  = out_last;
        if (in_valid && in_ready) begin
          acc_cnt++;
          img[mr][mc] = in_pixel;
          if (mr >= 2 && mc >= 2)
            sb_q.push_back('{model_window(mr, mc), (mr == H-1 && mc == W-1)});
          if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
          end else begin
            mc++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_pixel(input int pix, input bit gaps);
    bit acc;
    int g;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_pixel = PW'(pix);
    g = 0;
    acc = 1'b0;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) chk(1'b0, "accept_timeout", WW'(g), WW'(200));
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(base + r*W + c, gaps);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || out_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(sb_q.size() == 0, "drain", WW'(sb_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk(out_valid === 1'b0, "rst_out_valid", WW'(out_valid), '0);
    chk(out_last === 1'b0, "rst_out_last", WW'(out_last), '0);
    chk(out_window === '0, "rst_out_window", out_window, '0);
    chk(in_ready === 1'b1, "rst_in_ready", WW'(in_ready), WW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, w9(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
    tbl[1] = '{1, w9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    tbl[2] = '{2, w9(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
    tbl[3] = '{3, w9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};
    tbl[4] = '{4, w9(100, 101, 102, 104, 105, 106, 108, 109, 110), 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1; ready_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two gap-free back-to-back frames checked against the table.
    cap_q.delete();
    send_frame(0, 1'b0);
    chk(first_valid_acc == 11, "first_window_after_px10", WW'(first_valid_acc), WW'(11));
    send_frame(100, 1'b0);
    drain();
    chk(cap_q.size() == 8, "window_count_2frames", WW'(cap_q.size()), WW'(8));
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].cap_idx < cap_q.size()) begin
        chk(cap_q[tbl[i].cap_idx].win === tbl[i].win, "tbl_window",
            cap_q[tbl[i].cap_idx].win, tbl[i].win);
        chk(cap_q[tbl[i].cap_idx].last === tbl[i].last, "tbl_last",
            WW'(cap_q[tbl[i].cap_idx].last), WW'(tbl[i].last));
      end else begin
        chk(1'b0, "tbl_missing", WW'(cap_q.size()), WW'(tbl[i].cap_idx));
      end
    end

    // Downstream stall of 5 cycles on the first window of a frame.
    ready_mode = 2;
    @(posedge clk);
    #1;
    fork
      send_frame(50, 1'b0);
      begin
        int g;
        g = 0;
        while (!out_valid && g < 100) begin @(negedge clk); g++; end
        chk(out_valid === 1'b1, "stall_wait_valid", WW'(out_valid), WW'(1));
        repeat (5) begin
          @(negedge clk);
          chk(in_ready === 1'b0, "stall_in_ready", WW'(in_ready), '0);
        end
        ready_mode = 0;
      end
    join
    drain();

    // Reset in the middle of a frame, then a fresh frame.
    for (int i = 0; i < 6; i++) send_pixel(i, 1'b0);
    do_reset();
    cap_q.delete();
    send_frame(0, 1'b0);
    drain();
    chk(first_valid_acc == 11, "post_rst_first_valid", WW'(first_valid_acc), WW'(11));
    chk(cap_q.size() == 4, "post_rst_count", WW'(cap_q.size()), WW'(4));
    for (int i = 0; i < 4; i++)
      if (i < cap_q.size())
        chk(cap_q[i].win === tbl[i].win, "post_rst_window", cap_q[i].win, tbl[i].win);

    // Random input gaps and output back-pressure over three frames.
    cap_q.delete();
    ready_mode = 1;
    send_frame(20, 1'b1);
    send_frame(40, 1'b1);
    send_frame(60, 1'b1);
    ready_mode = 0;
    drain();
    chk(cap_q.size() == 12, "random_count", WW'(cap_q.size()), WW'(12));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 The block SHALL have parameter IMAGE_WIDTH, default 512, meaning pixels per row.
REQ-002 The block SHALL have parameter IMAGE_HEIGHT, default 512, meaning rows per frame.
REQ-003 The block SHALL have parameter PIXEL_WIDTH, default 8, meaning bits per pixel.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  upstream pixel present.
REQ-007 in_ready  out  1  block accepts pixel this cycle.
REQ-008 in_pixel  in  PIXEL_WIDTH  raster-order pixel.
REQ-009 out_valid  out  1  window present.
REQ-010 out_ready  in  1  downstream convolution stage accepts window.
REQ-011 out_window  out  9*PIXEL_WIDTH  3x3 window, element k at bits [PIXEL_WIDTH*k +: PIXEL_WIDTH].
REQ-012 out_last  out  1  window is last of frame.

Function
REQ-013 Accept SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready, combinationally.
REQ-014 Column counter 0..IMAGE_WIDTH-1 SHALL increment per accept; on wrap it returns to 0 and row counter increments.
REQ-015 Row counter 0..IMAGE_HEIGHT-1 SHALL wrap to 0 after the last pixel of a frame; the next accept is pixel (0,0) of a new frame.
REQ-016 Two line buffers of IMAGE_WIDTH entries SHALL hold rows r-2 and r-1; on accept at column c: read both at c, write old row r-1 entry into row r-2 buffer, write in_pixel into row r-1 buffer.
REQ-017 Three 3-deep column shift registers (top/mid/bottom) SHALL shift on every accept, loading line-buffer reads and in_pixel.
REQ-018 Window order SHALL be row-major matching package kernel index order: k=0 top-left (row r-2, col c-2) ... k=8 bottom-right (current pixel).
REQ-019 A window SHALL be emitted only for accepts with row>=2 and col>=2; no border padding; (W-2)*(H-2) windows per frame.
REQ-020 Latency SHALL be 1 cycle: out_valid rises the cycle after the qualifying accept, window registered.
REQ-021 out_valid && !out_ready SHALL hold out_window, out_last, out_valid stable and deassert in_ready.
REQ-022 out_valid && out_ready with a same-cycle qualifying accept SHALL load the new window without a bubble; without one, out_valid SHALL drop.
REQ-023 out_last SHALL be 1 only with the window produced by pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
REQ-024 Line-buffer contents SHALL never be cleared; stale rows from previous frames are invisible due to REQ-019 gating.

Reset
REQ-025 rst SHALL set out_valid=0, out_last=0, out_window=0, both counters=0, shift registers=0; in_ready therefore 1.
REQ-026 rst mid-frame SHALL discard the partial frame; the next accept after release is pixel (0,0).

Structure
REQ-027 IMAGE_HEIGHT (512) and PIXEL_WIDTH (8) SHALL be added to definitions_pkg beside IMAGE_WIDTH, and SHALL supply the module parameter defaults.
REQ-028 definitions_pkg SHALL define pixel_window_t, 9-element array of PIXEL_WIDTH-bit pixels, used by this block and downstream Gaussian/Sobel stages.
REQ-029 One sub-module, window_line_ram (IMAGE_WIDTH x PIXEL_WIDTH, combinational read, synchronous write), SHALL be instantiated twice.

Verification (bench uses IMAGE_WIDTH=4, IMAGE_HEIGHT=4, pixel=row*4+col, out_ready=1 unless stated)
REQ-030 Single frame, in_valid always 1 -> exactly 4 windows; first after pixel 10 = {0,1,2,4,5,6,8,9,10}; no out_valid before.
REQ-031 Same frame -> final window {5,6,7,9,10,11,13,14,15} with out_last=1; other three have out_last=0.
REQ-032 out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, window unchanged, no pixel lost; release gives identical window sequence.
REQ-033 Two back-to-back frames, second frame pixel=100+row*4+col -> second frame first window {100,101,102,104,105,106,108,109,110}, no first-frame data.
REQ-034 rst after 6 accepts, then fresh frame -> out_valid=0 until 11th accept of new frame; window values per REQ-030.
REQ-035 Random in_valid/out_ready gaps over 3 frames -> output sequence matches gap-free reference model.
